// File: rtl/spi_frontend_burst.sv
// SPI slave frontend: command word (R/W + address) followed by an unbounded burst of
// data words; writes pulse wr_en per word, reads prefetch via rd_req/rdata onto poci.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | cs high or frame not started; first edge takes command bit 0
// S_CMD   | shifting in the rest of the 1+ADDR_W bit command word
// S_WDATA | shifting in write data words, wr_en after each complete word
// S_DUMMY | turnaround edges, pico ignored; last edge loads first read word
// S_RDATA | shifting read data out on poci, next word fetched on LSB edge
module spi_frontend_burst #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int DUMMY    = 1,
    parameter int AUTO_INC = 1
) (
    input  logic              spi_clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              pico,
    output logic              poci,
    output logic              is_write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              wr_en,
    output logic              rd_req,
    input  logic [DATA_W-1:0] rdata
);

    localparam int CMD_W = ADDR_W + 1;
    localparam int RX_N  = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int RX_W  = RX_N - 1;
    localparam int CNT_N = (RX_N > DUMMY) ? RX_N : DUMMY;
    localparam int CNT_W = $clog2(CNT_N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_DUMMY,
        S_RDATA
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [RX_W-1:0]   rx_sr;
    logic [DATA_W-1:0] tx_sr;
    logic              frame_clr;
    logic [CMD_W-1:0]  cmd_word;
    logic [DATA_W-1:0] data_word;
    logic              cmd_last;
    logic              dummy_last;
    logic              word_last;

    // cs high clears the frame but leaves is_write/addr/wdata alone
    assign frame_clr  = rst | cs;
    assign cmd_word   = {rx_sr[CMD_W-2:0], pico};
    assign data_word  = {rx_sr[DATA_W-2:0], pico};
    assign cmd_last   = (state == S_CMD) && (cnt == CNT_W'(CMD_W - 1));
    assign dummy_last = (state == S_DUMMY) && (cnt == CNT_W'(DUMMY - 1));
    assign word_last  = (cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge spi_clk or posedge frame_clr) begin
        if (frame_clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_CMD;
            S_CMD:   if (cmd_last) state_nxt = cmd_word[ADDR_W] ? S_WDATA : S_DUMMY;
            S_DUMMY: if (dummy_last) state_nxt = S_RDATA;
            default: state_nxt = state;
        endcase
    end

    // rd_req is decoded so the responder sees it for the whole cycle before the load edge
    always_comb begin
        rd_req = 1'b0;
        poci   = 1'b0;
        case (state)
            S_DUMMY: rd_req = dummy_last;
            S_RDATA: begin
                rd_req = word_last;
                poci   = tx_sr[DATA_W-1];
            end
            default: begin
                rd_req = 1'b0;
                poci   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge spi_clk or posedge frame_clr) begin
        if (frame_clr) begin
            cnt   <= '0;
            rx_sr <= '0;
            tx_sr <= '0;
            wr_en <= 1'b0;
        end else begin
            wr_en <= (state == S_WDATA) && word_last;
            case (state)
                S_IDLE:  cnt <= CNT_W'(1);
                S_CMD:   cnt <= cmd_last ? '0 : cnt + CNT_W'(1);
                S_DUMMY: cnt <= dummy_last ? '0 : cnt + CNT_W'(1);
                default: cnt <= word_last ? '0 : cnt + CNT_W'(1);
            endcase
            if ((state == S_IDLE) || (state == S_CMD) || (state == S_WDATA)) begin
                rx_sr <= (rx_sr << 1) | RX_W'(pico);
            end
            if (rd_req) begin
                tx_sr <= rdata;
            end else if (state == S_RDATA) begin
                tx_sr <= tx_sr << 1;
            end
        end
    end

    // Writes advance addr on the edge after wr_en, reads on the tx load edge
    always_ff @(posedge spi_clk or posedge rst) begin
        if (rst) begin
            is_write <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
        end else begin
            if (cmd_last) begin
                is_write <= cmd_word[ADDR_W];
                addr     <= cmd_word[ADDR_W-1:0];
            end else if ((AUTO_INC != 0) && (wr_en || rd_req)) begin
                addr <= addr + ADDR_W'(1);
            end
            if ((state == S_WDATA) && word_last) begin
                wdata <= data_word;
            end
        end
    end

endmodule
